// File: rtl/arm_imm_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : arm_imm_encoder
//  Description : Sequential encoder for ARM data-processing rotated
//                immediates. Searches for imm8/rot such that
//                value == ROR(imm8, 2*rot), testing LANES rotation
//                candidates per cycle. The lowest matching rot wins, which
//                gives the canonical encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
module arm_imm_encoder #(
    parameter int LANES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] value,
    output logic        busy,
    output logic        done,
    output logic        found,
    output logic [7:0]  imm8,
    output logic [3:0]  rot,
    output logic [11:0] imm12
);

    // Number of candidate groups; the last group index ends the search.
    localparam int         C_NGROUPS = 16 / LANES;
    localparam logic [3:0] C_LAST_K  = 4'(C_NGROUPS - 1);

    // Only power-of-two lane counts up to 16 divide the 16 rotations evenly.
    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
        $error("arm_imm_encoder: LANES must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_value;
    logic [3:0]  r_k;
    logic        r_found;
    logic [7:0]  r_imm8;
    logic [3:0]  r_rot;

    logic [3:0]       w_base;
    logic [LANES-1:0] w_hit;
    logic [7:0]       w_byte [LANES];
    logic [3:0]       w_cand [LANES];
    logic             w_any;
    logic [7:0]       w_sel_byte;
    logic [3:0]       w_sel_rot;
    logic             w_accept;
    logic             w_last;

    // Rotate left through a doubled copy so a shift of zero needs no special case.
    function automatic logic [31:0] rol32(input logic [31:0] v, input logic [4:0] sh);
        logic [63:0] dbl;
        dbl = {v, v} << sh;
        return dbl[63:32];
    endfunction

    // First candidate rotation of the current group.
    assign w_base = 4'(int'(r_k) * LANES);

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        logic [31:0] w_rol;
        assign w_cand[j] = w_base + 4'(j);
        assign w_rol     = rol32(r_value, {w_cand[j], 1'b0});
        assign w_hit[j]  = (w_rol[31:8] == 24'd0);
        assign w_byte[j] = w_rol[7:0];
    end

    // Priority select: scanning downward lets the lowest hitting lane win.
    always_comb begin
        w_any      = 1'b0;
        w_sel_byte = 8'd0;
        w_sel_rot  = 4'd0;
        for (int j = LANES - 1; j >= 0; j--) begin
            if (w_hit[j]) begin
                w_any      = 1'b1;
                w_sel_byte = w_byte[j];
                w_sel_rot  = w_cand[j];
            end
        end
    end

    assign w_accept = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_last   = (r_k == C_LAST_K);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: a hit or an exhausted last group ends the search.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_SEARCH;
            S_SEARCH: if (w_any || w_last) w_next = S_DONE;
            S_DONE:   w_next = start ? S_SEARCH : S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Datapath: capture on accept, step the group index, latch the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_value <= 32'd0;
            r_k     <= 4'd0;
            r_found <= 1'b0;
            r_imm8  <= 8'd0;
            r_rot   <= 4'd0;
        end else if (w_accept) begin
            r_value <= value;
            r_k     <= 4'd0;
            r_found <= 1'b0;
            r_imm8  <= 8'd0;
            r_rot   <= 4'd0;
        end else if (r_state == S_SEARCH) begin
            if (w_any) begin
                r_found <= 1'b1;
                r_imm8  <= w_sel_byte;
                r_rot   <= w_sel_rot;
            end else if (w_last) begin
                r_found <= 1'b0;
                r_imm8  <= 8'd0;
                r_rot   <= 4'd0;
            end else begin
                r_k     <= r_k + 4'd1;
            end
        end
    end

    assign busy  = (r_state == S_SEARCH);
    assign done  = (r_state == S_DONE);
    assign found = r_found;
    assign imm8  = r_imm8;
    assign rot   = r_rot;
    assign imm12 = {r_rot, r_imm8};

endmodule
`default_nettype wire

// File: tb/tb_arm_imm_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arm_imm_encoder
//  Description : Directed bench for arm_imm_encoder with LANES=1 and LANES=4
//                instances; checks results, latency, handshake and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_arm_imm_encoder;

    logic        clk;
    logic        rst;
    logic        start1, start4;
    logic [31:0] value1, value4;
    logic        busy1, done1, found1;
    logic        busy4, done4, found4;
    logic [7:0]  imm8_1, imm8_4;
    logic [3:0]  rot1, rot4;
    logic [11:0] imm12_1, imm12_4;

    int checks;
    int errors;

    // Which instance the tasks talk to: 0 = LANES=1, 1 = LANES=4.
    logic        sel;
    logic        s_busy, s_done, s_found;
    logic [7:0]  s_imm8;
    logic [3:0]  s_rot;
    logic [11:0] s_imm12;

    assign s_busy  = sel ? busy4  : busy1;
    assign s_done  = sel ? done4  : done1;
    assign s_found = sel ? found4 : found1;
    assign s_imm8  = sel ? imm8_4 : imm8_1;
    assign s_rot   = sel ? rot4   : rot1;
    assign s_imm12 = sel ? imm12_4 : imm12_1;

    arm_imm_encoder #(.LANES(1)) u_dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .value (value1),
        .busy  (busy1),
        .done  (done1),
        .found (found1),
        .imm8  (imm8_1),
        .rot   (rot1),
        .imm12 (imm12_1)
    );

    arm_imm_encoder #(.LANES(4)) u_dut4 (
        .clk   (clk),
        .rst   (rst),
        .start (start4),
        .value (value4),
        .busy  (busy4),
        .done  (done4),
        .found (found4),
        .imm8  (imm8_4),
        .rot   (rot4),
        .imm12 (imm12_4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic s, input logic [31:0] v);
        if (sel) begin
            start4 = s;
            value4 = v;
        end else begin
            start1 = s;
            value1 = v;
        end
    endtask

    // Present a request now; it is accepted at the next rising edge.
    task automatic launch(input logic [31:0] v, input string tag);
        drive(1'b1, v);
        @(posedge clk);
        #1;
        drive(1'b0, v);
        chk({tag, "_busy"}, 32'(s_busy), 32'd1);
        chk({tag, "_clr"}, {19'd0, s_found, s_imm12}, 32'd0);
    endtask

    // Wait for done and check result and latency (cycles from start incl. start cycle).
    // inject_at > 0 pulses a competing start with another value mid-search.
    task automatic wait_check(input logic exp_found, input logic [7:0] exp_imm8,
                              input logic [3:0] exp_rot, input int exp_lat,
                              input int inject_at, input string tag);
        int n;
        bit got;
        n   = 1;
        got = 1'b0;
        while (n <= 40) begin
            if (n == inject_at) drive(1'b1, 32'h0000_00FF);
            else                drive(1'b0, 32'h1234_5678);
            @(posedge clk);
            #1;
            if (s_done) begin
                got = 1'b1;
                break;
            end
            n++;
        end
        drive(1'b0, 32'd0);
        chk({tag, "_lat"}, got ? 32'(n + 1) : 32'd0, 32'(exp_lat));
        chk({tag, "_found"}, 32'(s_found), 32'(exp_found));
        chk({tag, "_imm8"}, 32'(s_imm8), 32'(exp_imm8));
        chk({tag, "_rot"}, 32'(s_rot), 32'(exp_rot));
        chk({tag, "_imm12"}, 32'(s_imm12), {20'd0, exp_rot, exp_imm8});
        chk({tag, "_busy_done"}, 32'(s_busy), 32'd0);
    endtask

    // One cycle after done: pulse over, result held.
    task automatic check_hold(input logic exp_found, input logic [11:0] exp_imm12, input string tag);
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, {30'd0, s_done, s_busy}, 32'd0);
        chk({tag, "_hold"}, {19'd0, s_found, s_imm12}, {19'd0, exp_found, exp_imm12});
    endtask

    task automatic req(input logic [31:0] v, input logic exp_found, input logic [7:0] exp_imm8,
                       input logic [3:0] exp_rot, input int exp_lat, input string tag);
        @(negedge clk);
        launch(v, tag);
        wait_check(exp_found, exp_imm8, exp_rot, exp_lat, 0, tag);
        check_hold(exp_found, {exp_rot, exp_imm8}, tag);
    endtask

    initial begin
        int pulses;
        checks = 0;
        errors = 0;
        sel    = 1'b0;
        rst    = 1'b1;
        start1 = 1'b0;
        start4 = 1'b0;
        value1 = 32'd0;
        value4 = 32'd0;

        // Reset state of both instances.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_l1", {28'd0, busy1, done1, found1, 1'b0} | {20'd0, imm12_1}, 32'd0);
        chk("rst_l4", {28'd0, busy4, done4, found4, 1'b0} | {20'd0, imm12_4}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // LANES=1 directed vectors.
        sel = 1'b0;
        req(32'h0000_00FF, 1'b1, 8'hFF, 4'd0,  2,  "l1_ff");
        req(32'hF000_000F, 1'b1, 8'hFF, 4'd2,  4,  "l1_f00f");
        req(32'hFF00_0000, 1'b1, 8'hFF, 4'd4,  6,  "l1_ff000000");
        req(32'h0000_0104, 1'b1, 8'h41, 4'd15, 17, "l1_104");
        req(32'h0000_0102, 1'b0, 8'h00, 4'd0,  17, "l1_102");

        // LANES=4 directed vectors.
        sel = 1'b1;
        req(32'h0000_0104, 1'b1, 8'h41, 4'd15, 5, "l4_104");
        req(32'h0000_0000, 1'b1, 8'h00, 4'd0,  2, "l4_zero");
        req(32'h0000_0102, 1'b0, 8'h00, 4'd0,  5, "l4_102");
        req(32'h0003_FC00, 1'b1, 8'hFF, 4'd11, 4, "l4_3fc00");

        // Start while busy is ignored; the first request's result comes back.
        sel = 1'b0;
        @(negedge clk);
        launch(32'h0000_0104, "ign");
        wait_check(1'b1, 8'h41, 4'd15, 17, 3, "ign");
        check_hold(1'b1, 12'hF41, "ign");

        // Back-to-back: a start in the DONE cycle is accepted.
        @(negedge clk);
        launch(32'hF000_000F, "b2b_a");
        wait_check(1'b1, 8'hFF, 4'd2, 4, 0, "b2b_a");
        launch(32'hFF00_0000, "b2b_b");
        wait_check(1'b1, 8'hFF, 4'd4, 6, 0, "b2b_b");
        check_hold(1'b1, 12'h4FF, "b2b_b");

        // Reset during search aborts with no done pulse.
        @(negedge clk);
        launch(32'h0000_0104, "rst_mid");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_state", {28'd0, busy1, done1, found1, 1'b0} | {20'd0, imm12_1}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done1) pulses++;
        end
        chk("rst_mid_nodone", 32'(pulses), 32'd0);
        req(32'h0000_00FF, 1'b1, 8'hFF, 4'd0, 2, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/arm_imm_encoder.md
Name: arm_imm_encoder

Overview:
- Sequential encoder for ARM data-processing rotated immediates: the inverse of the operand-2 immediate rotate path.
- Given a 32-bit constant, searches for imm8/rot4 such that value == ROR(imm8, 2*rot).
- Used by the instruction-build/self-test logic to produce operand-2 fields.
- Start/busy/done handshake; tests LANES rotation candidates per cycle.

Parameters:
LANES, 1, rotation candidates tested per cycle; legal values 1, 2, 4, 8, 16 (elaboration error otherwise)

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; accepted only when busy=0
value  input  32  constant to encode; sampled on accepted start
busy  output  1  high while search in progress
done  output  1  one-cycle pulse when result valid
found  output  1  1 = value is encodable; valid from done, held until next accept
imm8  output  8  unrotated byte; 0 when found=0
rot  output  4  rotate field (rotate right by 2*rot); 0 when found=0
imm12  output  12  {rot, imm8}, the ARM operand-2 immediate field

Behaviour:
- Reset (rst=1 at clock edge): state IDLE; busy=0, done=0, found=0, imm8=0, rot=0, imm12=0; candidate counter cleared. Reset during SEARCH aborts the search with no done pulse.
- FSM states: IDLE, SEARCH, DONE.
- IDLE or DONE with start=1:
  - capture value into internal register;
  - set group index k=0;
  - go to SEARCH; busy=1 from the next cycle.
- Back-to-back requests: a start in the DONE cycle is accepted.
- SEARCH, group k: candidates are r = k*LANES + j, for j = 0..LANES-1.
  - Hit test for candidate r: upper 24 bits of ROL(captured, 2r) are zero.
  - Rotate amounts are mod 32; r=0 means no rotation.
- Priority: the lowest hit r wins, both within a group and across groups. This gives the canonical encoding.
- On any hit in group k, at the next edge:
  - found=1, imm8 = low byte of ROL(captured, 2r), rot=r;
  - go to DONE.
- On no hit in the last group (k = 16/LANES - 1), at the next edge:
  - found=0, imm8=0, rot=0;
  - go to DONE.
- Otherwise k increments and the FSM stays in SEARCH.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE (or SEARCH if start is accepted).
- Latency, start accepted at edge T:
  - hit at r: done high in the cycle after edge T+1+floor(r/LANES);
  - miss: done high in the cycle after edge T+16/LANES.
  - LANES=1: best case 2 cycles, worst case 17 cycles from start.
- start while busy=1 is ignored; value changes during a search have no effect.
- found, imm8, rot and imm12 hold their values from DONE until the next accepted start.
- On accept they clear to 0 and stay 0 until the next DONE.
- Value 0 encodes as found=1, imm8=0x00, rot=0.

Test Plan:
- LANES=1, start with value=0x000000FF → done 2 cycles after start, found=1, imm8=0xFF, rot=0, imm12=0x0FF.
- LANES=1, value=0xF000000F → found=1, imm8=0xFF, rot=2, imm12=0x2FF, done 4 cycles after start; value=0xFF000000 → rot=4, imm8=0xFF, done 6 cycles after start.
- LANES=1, value=0x00000104 → found=1, imm8=0x41, rot=15, done 17 cycles after start; value=0x00000102 (odd alignment) → found=0, imm8=0, rot=0, done 17 cycles after start.
- LANES=4, value=0x00000104 → same result (imm8=0x41, rot=15), done 5 cycles after start; value=0x00000000 → found=1, imm12=0x000, done 2 cycles after start.
- Handshake: start pulsed again mid-search with a different value → ignored, first result returned. New start in the DONE cycle → accepted, second done follows at the correct latency.
- Reset: assert rst during SEARCH → next cycle busy=0, done=0, found=0, imm12=0, and no done pulse. A fresh start after reset behaves normally.
